hyperram_responder: RTL and testbench



---
 rtl/hyperbus_pkg.sv | 55 +++++
 rtl/hyperram_responder_mem.sv | 40 ++++
 rtl/hyperram_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_hyperram_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_pkg
// Description : Shared HyperBus definitions: CR0 latency codes, CR0 reset
//               value, command/address bit positions, responder states and
//               the first-data-cycle helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hyperbus_pkg;

  // CR0[7:4] initial-latency codes
  localparam logic [3:0] LAT3 = 4'hE;
  localparam logic [3:0] LAT4 = 4'hF;
  localparam logic [3:0] LAT5 = 4'h0;
  localparam logic [3:0] LAT6 = 4'h1;

  // CR0 after reset: L=6, fixed 2x latency
  localparam logic [15:0] CR0_RST = 16'h8F1F;
  // CR0 bit forcing 2x latency on every transaction
  localparam int CR0_FIXED_BIT = 3;

  // Command/address bit positions within the 48-bit CA word
  localparam int CA_RW     = 47;
  localparam int CA_AS     = 46;
  localparam int CA_BURST  = 45;
  localparam int CA_ROW_HI = 33;
  localparam int CA_ROW_LO = 16;
  localparam int CA_COL_HI = 2;
  localparam int CA_COL_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CA    = 3'd1,
    ST_LAT   = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4,
    ST_REGWR = 3'd5,
    ST_DRAIN = 3'd6
  } state_e;

  // Counted-cycle index of the first data word: 2 + L * (m2 ? 2 : 1)
  function automatic logic [4:0] first_data_cycle(input logic [3:0] code, input logic m2);
    logic [4:0] lat;
    case (code)
      LAT3:    lat = 5'd3;
      LAT4:    lat = 5'd4;
      LAT5:    lat = 5'd5;
      LAT6:    lat = 5'd6;
      default: lat = 5'd6;
    endcase
    return m2 ? (5'd2 + (lat << 1)) : (5'd2 + lat);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hyperram_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : hyperram_mem
// Description : Single-port 2^ADDR_W x 16 RAM, 2-bit byte enable,
//               synchronous read (block-RAM style, contents not reset).
// Revision    : 1.0 - initial release
// ============================================================================
module hyperram_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  // Byte-masked write or registered read, one access per cycle
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hyperram_responder.sv
`default_nettype none
// ============================================================================
// Module      : hyperram_responder
// Description : HyperRAM device model on a DDR-pair HyperBus boundary.
//               Decodes CA, applies 1x/2x initial latency, serves linear
//               word bursts from internal RAM and CR0 register accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperram_responder
  import hyperbus_pkg::*;
#(
  parameter int          ADDR_W = 12,
  parameter logic [15:0] ID0    = 16'h0C81
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        ck_e,
  input  logic [7:0]  dq_in_ris,
  input  logic [7:0]  dq_in_fal,
  input  logic        rwds_in_ris,
  input  logic        rwds_in_fal,
  input  logic        lat2x_req,
  output logic [7:0]  dq_out_ris,
  output logic [7:0]  dq_out_fal,
  output logic        dq_oen,
  output logic        rwds_out_ris,
  output logic        rwds_out_fal,
  output logic        rwds_oen,
  output logic [15:0] cr0,
  output logic        busy
);

  state_e            state_q, state_d;
  logic [15:0]       cr0_q, cr0_d;
  logic              rw_q, rw_d;
  logic              as_q, as_d;
  logic              m2_q, m2_d;
  logic [1:0]        row_hi_q, row_hi_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dq_ris_q, dq_ris_d;
  logic [7:0]        dq_fal_q, dq_fal_d;
  logic              dq_oen_q, dq_oen_d;
  logic              rwds_ris_q, rwds_ris_d;
  logic              rwds_fal_q, rwds_fal_d;
  logic              rwds_oen_q, rwds_oen_d;

  logic              w_mem_en;
  logic              w_mem_we;
  logic [1:0]        w_mem_be;
  logic [15:0]       w_mem_rdata;
  logic [15:0]       w_rd_word;
  logic [4:0]        w_first_cyc;
  logic              w_m2_new;

  assign w_m2_new    = cr0_q[CR0_FIXED_BIT] | lat2x_req;
  assign w_first_cyc = first_data_cycle(cr0_q[7:4], m2_q);
  assign w_rd_word   = as_q ? ID0 : w_mem_rdata;

  hyperram_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .en_i    (w_mem_en),
    .we_i    (w_mem_we),
    .be_i    (w_mem_be),
    .addr_i  (addr_q),
    .wdata_i ({dq_in_ris, dq_in_fal}),
    .rdata_o (w_mem_rdata)
  );

  // State and output registers; reset aborts any burst, RAM keeps contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cr0_q      <= CR0_RST;
      rw_q       <= 1'b0;
      as_q       <= 1'b0;
      m2_q       <= 1'b0;
      row_hi_q   <= 2'b00;
      cnt_q      <= '0;
      addr_q     <= '0;
      dq_ris_q   <= '0;
      dq_fal_q   <= '0;
      dq_oen_q   <= 1'b1;
      rwds_ris_q <= 1'b0;
      rwds_fal_q <= 1'b0;
      rwds_oen_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cr0_q      <= cr0_d;
      rw_q       <= rw_d;
      as_q       <= as_d;
      m2_q       <= m2_d;
      row_hi_q   <= row_hi_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dq_ris_q   <= dq_ris_d;
      dq_fal_q   <= dq_fal_d;
      dq_oen_q   <= dq_oen_d;
      rwds_ris_q <= rwds_ris_d;
      rwds_fal_q <= rwds_fal_d;
      rwds_oen_q <= rwds_oen_d;
    end
  end

  // Next state, next outputs and RAM access for the cycle on the inputs
  always_comb begin
    state_d    = state_q;
    cr0_d      = cr0_q;
    rw_d       = rw_q;
    as_d       = as_q;
    m2_d       = m2_q;
    row_hi_d   = row_hi_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dq_ris_d   = dq_ris_q;
    dq_fal_d   = dq_fal_q;
    dq_oen_d   = dq_oen_q;
    rwds_ris_d = rwds_ris_q;
    rwds_fal_d = rwds_fal_q;
    rwds_oen_d = rwds_oen_q;
    w_mem_en   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_be   = 2'b00;

    if (cs_n) begin
      // Deselect ends or aborts everything and releases the bus
      state_d    = ST_IDLE;
      cnt_d      = '0;
      dq_ris_d   = '0;
      dq_fal_d   = '0;
      dq_oen_d   = 1'b1;
      rwds_ris_d = 1'b0;
      rwds_fal_d = 1'b0;
      rwds_oen_d = 1'b1;
    end else if (ck_e) begin
      // Cycles without ck_e fall through: everything holds
      case (state_q)
        ST_IDLE: begin
          rw_d       = dq_in_ris[CA_RW - 40];
          as_d       = dq_in_ris[CA_AS - 40];
          row_hi_d   = dq_in_fal[CA_ROW_HI - 32:0];
          m2_d       = w_m2_new;
          cnt_d      = 5'd1;
          rwds_oen_d = 1'b0;
          rwds_ris_d = w_m2_new;
          rwds_fal_d = w_m2_new;
          dq_oen_d   = 1'b1;
          state_d    = ST_CA;
        end
        ST_CA: begin
          if (cnt_q == 5'd1) begin
            addr_d = ADDR_W'({row_hi_q, dq_in_ris, dq_in_fal, 3'b000});
            cnt_d  = 5'd2;
          end else begin
            addr_d  = {addr_q[ADDR_W-1:3], dq_in_fal[CA_COL_HI:CA_COL_LO]};
            cnt_d   = 5'd3;
            state_d = (!rw_q && as_q) ? ST_REGWR : ST_LAT;
          end
        end
        ST_LAT: begin
          rwds_oen_d = 1'b1;
          rwds_ris_d = 1'b0;
          rwds_fal_d = 1'b0;
          cnt_d      = cnt_q + 5'd1;
          if (cnt_q == w_first_cyc - 5'd1) begin
            if (rw_q) begin
              // Prefetch the first word so it is ready for the first data cycle
              w_mem_en = 1'b1;
              addr_d   = addr_q + ADDR_W'(1);
              state_d  = ST_RDATA;
            end else begin
              state_d  = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          dq_oen_d   = 1'b0;
          dq_ris_d   = w_rd_word[15:8];
          dq_fal_d   = w_rd_word[7:0];
          rwds_oen_d = 1'b0;
          rwds_ris_d = 1'b1;
          rwds_fal_d = 1'b0;
          w_mem_en   = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
        end
        ST_WDATA: begin
          w_mem_en = 1'b1;
          w_mem_we = 1'b1;
          w_mem_be = {~rwds_in_ris, ~rwds_in_fal};
          addr_d   = addr_q + ADDR_W'(1);
        end
        ST_REGWR: begin
          cr0_d      = {dq_in_ris, dq_in_fal};
          rwds_oen_d = 1'b1;
          rwds_ris_d = 1'b0;
          rwds_fal_d = 1'b0;
          state_d    = ST_DRAIN;
        end
        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign dq_out_ris   = dq_ris_q;
  assign dq_out_fal   = dq_fal_q;
  assign dq_oen       = dq_oen_q;
  assign rwds_out_ris = rwds_ris_q;
  assign rwds_out_fal = rwds_fal_q;
  assign rwds_oen     = rwds_oen_q;
  assign cr0          = cr0_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hyperram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperram_responder
// Description : Self-checking bench: transaction-level HyperRAM model with
//               randomized bursts, latencies, masks, gaps and aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperram_responder;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] ID0_V = 16'h0C81;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n, ck_e;
  logic [7:0]  dq_in_ris, dq_in_fal;
  logic        rwds_in_ris, rwds_in_fal, lat2x_req;
  logic [7:0]  dq_out_ris, dq_out_fal;
  logic        dq_oen, rwds_out_ris, rwds_out_fal, rwds_oen, busy;
  logic [15:0] cr0;

  hyperram_responder #(.ADDR_W(AW), .ID0(ID0_V)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .ck_e(ck_e),
    .dq_in_ris(dq_in_ris), .dq_in_fal(dq_in_fal),
    .rwds_in_ris(rwds_in_ris), .rwds_in_fal(rwds_in_fal),
    .lat2x_req(lat2x_req),
    .dq_out_ris(dq_out_ris), .dq_out_fal(dq_out_fal), .dq_oen(dq_oen),
    .rwds_out_ris(rwds_out_ris), .rwds_out_fal(rwds_out_fal),
    .rwds_oen(rwds_oen), .cr0(cr0), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [15:0] mdl_mem [DEPTH];
  logic [15:0] mdl_cr0;
  logic [15:0] wq[$];
  logic [1:0]  mq[$];

  // Expected outputs for the cycle most recently driven
  bit          exp_valid = 0;
  bit          exp_rst;
  logic        exp_busy, exp_dq_oen, exp_rwds_oen, exp_rwds_r, exp_rwds_f;
  logic [15:0] exp_dq, exp_cr0;
  int          exp_n = -1;

  // Observations used by the literal checks
  bit          seen_first;
  logic [15:0] first_rd_word;
  int          first_rd_cyc;
  logic        c0_rwds;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Compare process: DUT outputs just after each active edge
  always @(posedge clk) begin
    #1;
    if (exp_valid) begin
      chk("busy", busy, exp_busy);
      chk("dq_oen", dq_oen, exp_dq_oen);
      chk("rwds_oen", rwds_oen, exp_rwds_oen);
      chk("cr0", cr0, exp_cr0);
      if (!exp_rwds_oen) begin
        chk("rwds_ris", rwds_out_ris, exp_rwds_r);
        chk("rwds_fal", rwds_out_fal, exp_rwds_f);
      end
      if (!exp_dq_oen) chk("dq_word", {dq_out_ris, dq_out_fal}, exp_dq);
      if (exp_rst) chk("rst_zero", {dq_out_ris, dq_out_fal, rwds_out_ris, rwds_out_fal}, 18'd0);
      if (exp_n == 0) c0_rwds = rwds_out_ris;
      if (dq_oen === 1'b0 && !seen_first) begin
        seen_first    = 1;
        first_rd_word = {dq_out_ris, dq_out_fal};
        first_rd_cyc  = exp_n;
      end
    end
  end

  function automatic int lat_of(input logic [3:0] code);
    case (code)
      4'hE:    return 3;
      4'hF:    return 4;
      4'h0:    return 5;
      default: return 6;
    endcase
  endfunction

  task automatic drive(input logic cs, input logic cke, input logic [7:0] dr, input logic [7:0] df,
                       input logic mr, input logic mf, input logic l2x);
    @(negedge clk);
    cs_n = cs; ck_e = cke; dq_in_ris = dr; dq_in_fal = df;
    rwds_in_ris = mr; rwds_in_fal = mf; lat2x_req = l2x;
  endtask

  task automatic set_idle_exp(input bit rst_vals);
    exp_valid = 1; exp_rst = rst_vals; exp_busy = 0;
    exp_dq_oen = 1; exp_rwds_oen = 1; exp_n = -1; exp_cr0 = mdl_cr0;
  endtask

  task automatic rnd_cycle(input logic cs, input logic cke);
    drive(cs, cke, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One transaction; write data comes from wq/mq.  abort_at: counted cycle
  // replaced by deselect (or by reset when abort_rst), -1 for none.
  task automatic txn(input bit rd, input bit rsp, input logic [20:0] wa, input bit l2x,
                     input int nw, input int gap_pct, input int force_gap_n,
                     input int abort_at, input bit abort_rst);
    bit          m2, is_regwr, is_wmem;
    int          d, last, a, idx;
    logic [47:0] ca;
    logic [15:0] w, word;
    logic [1:0]  mk;
    m2       = mdl_cr0[3] | l2x;
    d        = 2 + (m2 ? 2 * lat_of(mdl_cr0[7:4]) : lat_of(mdl_cr0[7:4]));
    ca       = {rd, rsp, 1'b1, 11'd0, wa[20:3], 13'd0, wa[2:0]};
    is_regwr = !rd && rsp;
    is_wmem  = !rd && !rsp;
    last     = is_regwr ? 5 : d + nw - 1;
    a        = int'(wa % DEPTH);
    seen_first = 0;
    for (int n = 0; n <= last; n++) begin
      if (n == abort_at) break;
      if (n > 0 && (n == force_gap_n || $urandom_range(99) < gap_pct)) begin
        rnd_cycle(1'b0, 1'b0);
        exp_n = -1;
      end
      w = 16'($urandom); mk = 2'($urandom);
      if (n < 3) w = ca[47 - 16*n -: 16];
      else if ((is_regwr && n == 3) || (is_wmem && n >= d)) begin
        w = wq.pop_front(); mk = mq.pop_front();
      end
      drive(1'b0, 1'b1, w[15:8], w[7:0], mk[1], mk[0], (n == 0) ? l2x : 1'($urandom));
      exp_valid = 1; exp_rst = 0; exp_busy = 1; exp_n = n;
      exp_dq_oen = 1; exp_rwds_oen = 1;
      idx = (a + n - d) % DEPTH;
      if (n <= 2) begin
        exp_rwds_oen = 0; exp_rwds_r = m2; exp_rwds_f = m2;
      end else if (rd && n >= d) begin
        word = rsp ? ID0_V : mdl_mem[idx];
        exp_dq_oen = 0; exp_dq = word;
        exp_rwds_oen = 0; exp_rwds_r = 1; exp_rwds_f = 0;
      end
      if (is_regwr && n == 3) mdl_cr0 = w;
      if (is_wmem && n >= d) begin
        if (!mk[1]) mdl_mem[idx][15:8] = w[15:8];
        if (!mk[0]) mdl_mem[idx][7:0]  = w[7:0];
      end
      exp_cr0 = mdl_cr0;
    end
    if (abort_rst && abort_at >= 0) begin
      @(negedge clk);
      reset = 1'b1;
      mdl_cr0 = 16'h8F1F;
      set_idle_exp(1);
      rnd_cycle(1'b1, 1'b0);
      reset = 1'b0;
    end else begin
      rnd_cycle(1'b1, 1'b0);
      set_idle_exp(0);
    end
    rnd_cycle(1'b1, 1'b0);
    set_idle_exp(0);
    wq.delete(); mq.delete();
  endtask

  task automatic push_w(input logic [15:0] w, input logic [1:0] mk);
    wq.push_back(w); mq.push_back(mk);
  endtask

  task automatic random_phase(input int count);
    int          kind, nw, ab;
    bit          rd, l2x;
    logic [20:0] wa;
    logic [15:0] cfg;
    for (int t = 0; t < count; t++) begin
      kind = $urandom_range(0, 9);
      wa   = 21'($urandom);
      l2x  = 1'($urandom);
      nw   = $urandom_range(1, 5);
      ab   = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 6) : -1;
      if (kind == 0) begin
        cfg = 16'($urandom);
        case ($urandom_range(0, 4))
          0: cfg[7:4] = 4'hE;
          1: cfg[7:4] = 4'hF;
          2: cfg[7:4] = 4'h0;
          3: cfg[7:4] = 4'h1;
          default: cfg[7:4] = 4'h7;
        endcase
        push_w(cfg, 2'b00);
        txn(1'b0, 1'b1, wa, l2x, 1, 15, -1, ab, 1'b0);
      end else if (kind == 1) begin
        txn(1'b1, 1'b1, wa, l2x, nw, 15, -1, ab, 1'b0);
      end else begin
        rd = 1'($urandom);
        if (!rd) for (int i = 0; i < nw; i++) push_w(16'($urandom), 2'($urandom));
        txn(rd, 1'b0, wa, l2x, nw, 15, -1, ab, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; ck_e = 1'b0; lat2x_req = 1'b0;
    dq_in_ris = '0; dq_in_fal = '0; rwds_in_ris = 1'b0; rwds_in_fal = 1'b0;
    mdl_cr0 = 16'h8F1F;
    @(negedge clk);
    set_idle_exp(1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_cr0", cr0, 16'h8F1F);

    // Fill every word (reset CR0: L=6, fixed 2x)
    for (int i = 0; i < DEPTH; i++) push_w(16'($urandom), 2'b00);
    txn(1'b0, 1'b0, 21'd0, 1'($urandom), DEPTH, 0, -1, -1, 1'b0);

    // Wrap from word 15 with a held cycle between the two beats
    txn(1'b1, 1'b0, 21'd15, 1'b0, 2, 0, 15, -1, 1'b0);
    chk("wrap_first_cyc", first_rd_cyc, 14);

    // Config write CA 60 00 01 00 00 00, data 8FE7
    push_w(16'h8FE7, 2'b00);
    txn(1'b0, 1'b1, 21'h000800, 1'b0, 1, 0, -1, -1, 1'b0);
    chk("cfg_cr0", cr0, 16'h8FE7);

    // L=3, 1x: write then read BEEF
    push_w(16'hBEEF, 2'b00);
    txn(1'b0, 1'b0, 21'h012, 1'b0, 1, 0, -1, -1, 1'b0);
    txn(1'b1, 1'b0, 21'h012, 1'b0, 1, 0, -1, -1, 1'b0);
    chk("rd_beef", first_rd_word, 16'hBEEF);
    chk("rd_cyc_1x", first_rd_cyc, 5);
    chk("rwds_c0_1x", c0_rwds, 1'b0);

    // 2x requested at C0
    push_w(16'hCAFE, 2'b00);
    txn(1'b0, 1'b0, 21'h013, 1'b1, 1, 0, -1, -1, 1'b0);
    txn(1'b1, 1'b0, 21'h013, 1'b1, 1, 0, -1, -1, 1'b0);
    chk("rd_cafe", first_rd_word, 16'hCAFE);
    chk("rd_cyc_2x", first_rd_cyc, 8);
    chk("rwds_c0_2x", c0_rwds, 1'b1);

    // Upper byte masked
    push_w(16'h1234, 2'b10);
    txn(1'b0, 1'b0, 21'h012, 1'b0, 1, 0, -1, -1, 1'b0);
    txn(1'b1, 1'b0, 21'h012, 1'b0, 1, 0, -1, -1, 1'b0);
    chk("rd_mask", first_rd_word, 16'hBE34);

    // Write aborted at C4 leaves memory untouched
    push_w(16'h5555, 2'b00);
    txn(1'b0, 1'b0, 21'h012, 1'b0, 1, 0, -1, 4, 1'b0);
    txn(1'b1, 1'b0, 21'h012, 1'b0, 1, 0, -1, -1, 1'b0);
    chk("rd_after_abort", first_rd_word, 16'hBE34);

    // Reset during a read burst
    txn(1'b1, 1'b0, 21'h012, 1'b0, 3, 0, -1, 6, 1'b1);
    chk("cr0_after_rst", cr0, 16'h8F1F);
    txn(1'b1, 1'b0, 21'h012, 1'b0, 1, 0, -1, -1, 1'b0);
    chk("rd_after_rst", first_rd_word, 16'hBE34);

    random_phase(150);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
